// File: rtl/pc_sequencer.sv
// Program-counter sequencer: branch resolution, flags, halt state
// and saturating branch statistics.
module pc_sequencer #(
  parameter int              WIDTH    = 16,
  parameter int              IMM_W    = 9,
  parameter logic [WIDTH-1:0] RESET_PC = '0,
  parameter int              CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic [3:0]       opcode,
  input  logic [2:0]       cond,
  input  logic [IMM_W-1:0] imm,
  input  logic [WIDTH-1:0] rs_data,
  input  logic [2:0]       flags_in,
  input  logic [2:0]       flags_we,
  output logic [WIDTH-1:0] pc,
  output logic [WIDTH-1:0] pc_plus2,
  output logic             taken,
  output logic             flush,
  output logic             halted,
  output logic [2:0]       flags,
  output logic [CNT_W-1:0] br_cnt,
  output logic [CNT_W-1:0] tk_cnt
);

  localparam logic [3:0] OP_B   = 4'b1100;
  localparam logic [3:0] OP_BR  = 4'b1101;
  localparam logic [3:0] OP_HLT = 4'b1111;

  typedef enum logic {RUN, HALTED} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] pc_q, pc_d;
  logic             flush_q, flush_d;
  logic [2:0]       flags_q, flags_d;
  logic [CNT_W-1:0] br_q, br_d;
  logic [CNT_W-1:0] tk_q, tk_d;

  logic             z, v, n;
  logic             cond_ok;
  logic             is_br;
  logic             active;
  logic [WIDTH-1:0] imm_sx;
  logic [WIDTH-1:0] b_tgt;
  logic [WIDTH-1:0] tgt;

  assign z = flags_q[2];
  assign v = flags_q[1];
  assign n = flags_q[0];

  always_comb begin
    cond_ok = 1'b0;
    case (cond)
      3'b000: cond_ok = !z;
      3'b001: cond_ok = z;
      3'b010: cond_ok = !z && !n;
      3'b011: cond_ok = n;
      3'b100: cond_ok = z || (!z && !n);
      3'b101: cond_ok = z || n;
      3'b110: cond_ok = v;
      3'b111: cond_ok = 1'b1;
      default: cond_ok = 1'b0;
    endcase
  end

  assign active   = (state_q == RUN) && !stall;
  assign is_br    = (opcode == OP_B) || (opcode == OP_BR);
  assign taken    = active && is_br && cond_ok;
  assign pc_plus2 = pc_q + WIDTH'(2);

  // Halfword offset: sign-extend then scale by two, wrapping silently.
  assign imm_sx = {{(WIDTH-IMM_W){imm[IMM_W-1]}}, imm};
  assign b_tgt  = pc_plus2 + {imm_sx[WIDTH-2:0], 1'b0};
  assign tgt    = (opcode == OP_BR) ? rs_data : b_tgt;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    flags_d = flags_q;
    br_d    = br_q;
    tk_d    = tk_q;
    flush_d = taken;
    if (active) begin
      flags_d = (flags_q & ~flags_we) | (flags_in & flags_we);
      if (opcode == OP_HLT) begin
        state_d = HALTED;
      end else if (taken) begin
        pc_d = tgt;
      end else begin
        pc_d = pc_plus2;
      end
      if (is_br && (br_q != '1)) br_d = br_q + CNT_W'(1);
      if (taken && (tk_q != '1)) tk_d = tk_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= RUN;
      pc_q    <= RESET_PC;
      flush_q <= 1'b0;
      flags_q <= 3'b000;
      br_q    <= '0;
      tk_q    <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      flush_q <= flush_d;
      flags_q <= flags_d;
      br_q    <= br_d;
      tk_q    <= tk_d;
    end
  end

  assign pc     = pc_q;
  assign flush  = flush_q;
  assign halted = (state_q == HALTED);
  assign flags  = flags_q;
  assign br_cnt = br_q;
  assign tk_cnt = tk_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer; a second instance with a 4-bit
// counter width shares the stimulus to exercise saturation.
module tb_pc_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic [3:0]  opcode;
  logic [2:0]  cond;
  logic [8:0]  imm;
  logic [15:0] rs_data;
  logic [2:0]  flags_in;
  logic [2:0]  flags_we;

  logic [15:0] pc, pc_plus2;
  logic        taken, flush, halted;
  logic [2:0]  flags;
  logic [15:0] br_cnt, tk_cnt;

  logic [15:0] pc2, pc_plus2_2;
  logic        taken2, flush2, halted2;
  logic [2:0]  flags2;
  logic [3:0]  br_cnt2, tk_cnt2;

  int vecs = 0;
  int errs = 0;

  localparam logic [3:0] NOP = 4'b0000;
  localparam logic [3:0] B   = 4'b1100;
  localparam logic [3:0] BR  = 4'b1101;
  localparam logic [3:0] HLT = 4'b1111;

  always #5 clk = ~clk;

  pc_sequencer dut (
    .clk(clk), .rst(rst), .stall(stall), .opcode(opcode),
    .cond(cond), .imm(imm), .rs_data(rs_data),
    .flags_in(flags_in), .flags_we(flags_we),
    .pc(pc), .pc_plus2(pc_plus2), .taken(taken), .flush(flush),
    .halted(halted), .flags(flags), .br_cnt(br_cnt), .tk_cnt(tk_cnt)
  );

  pc_sequencer #(.CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .stall(stall), .opcode(opcode),
    .cond(cond), .imm(imm), .rs_data(rs_data),
    .flags_in(flags_in), .flags_we(flags_we),
    .pc(pc2), .pc_plus2(pc_plus2_2), .taken(taken2), .flush(flush2),
    .halted(halted2), .flags(flags2), .br_cnt(br_cnt2), .tk_cnt(tk_cnt2)
  );

  function automatic logic exp_cond(input logic [2:0] c,
                                    input logic [2:0] f);
    logic fz, fv, fn;
    fz = f[2]; fv = f[1]; fn = f[0];
    case (c)
      3'd0: return !fz;
      3'd1: return fz;
      3'd2: return !fz && !fn;
      3'd3: return fn;
      3'd4: return fz || !fn;
      3'd5: return fz || fn;
      3'd6: return fv;
      default: return 1'b1;
    endcase
  endfunction

  task automatic idle();
    stall = 0; opcode = NOP; cond = 0; imm = 0;
    rs_data = 0; flags_in = 0; flags_we = 0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1;
    idle();
    step();
    rst = 0;
    #2;
  endtask

  task automatic jump(input logic [15:0] a);
    idle();
    opcode = BR; cond = 3'b111; rs_data = a;
    step();
    idle();
  endtask

  task automatic test_reset();
    rst = 1;
    idle();
    #3;
    vecs++;
    if (pc !== 16'h0000 || halted !== 1'b0 || flush !== 1'b0) begin
      errs++;
      $display("FAIL reset_ctl: pc=%h halted=%b flush=%b want 0000/0/0",
               pc, halted, flush);
    end
    vecs++;
    if (flags !== 3'b000 || br_cnt !== 16'd0 || tk_cnt !== 16'd0) begin
      errs++;
      $display("FAIL reset_state: flags=%b br=%0d tk=%0d want 000/0/0",
               flags, br_cnt, tk_cnt);
    end
    vecs++;
    if (pc_plus2 !== 16'h0002) begin
      errs++;
      $display("FAIL reset_pc_plus2: got %h want 0002", pc_plus2);
    end
    step();
    rst = 0;
    #2;
  endtask

  task automatic test_branch_back();
    do_reset();
    for (int i = 0; i < 8; i++) step();
    vecs++;
    if (pc !== 16'h0010) begin
      errs++;
      $display("FAIL seq_to_10: pc=%h want 0010", pc);
    end
    opcode = B; cond = 3'b111; imm = 9'h1FE;
    #1;
    vecs++;
    if (taken !== 1'b1) begin
      errs++;
      $display("FAIL b_back_taken: got %b want 1", taken);
    end
    step();
    idle();
    vecs++;
    if (pc !== 16'h000E || flush !== 1'b1) begin
      errs++;
      $display("FAIL b_back_pc: pc=%h flush=%b want 000e/1", pc, flush);
    end
    vecs++;
    if (br_cnt !== 16'd1 || tk_cnt !== 16'd1) begin
      errs++;
      $display("FAIL b_back_cnt: br=%0d tk=%0d want 1/1", br_cnt, tk_cnt);
    end
    step();
    vecs++;
    if (flush !== 1'b0 || pc !== 16'h0010) begin
      errs++;
      $display("FAIL b_back_after: flush=%b pc=%h want 0/0010", flush, pc);
    end
  endtask

  task automatic test_flag_hazard();
    logic [15:0] p0;
    idle();
    flags_we = 3'b100; flags_in = 3'b100;
    step();
    vecs++;
    if (flags !== 3'b100) begin
      errs++;
      $display("FAIL set_z: flags=%b want 100", flags);
    end
    p0 = pc;
    opcode = B; cond = 3'b000; imm = 9'h010;
    flags_we = 3'b100; flags_in = 3'b000;
    #1;
    vecs++;
    if (taken !== 1'b0) begin
      errs++;
      $display("FAIL hazard_taken: got %b want 0", taken);
    end
    step();
    idle();
    vecs++;
    if (pc !== p0 + 16'd2 || flags !== 3'b000 || flush !== 1'b0) begin
      errs++;
      $display("FAIL hazard_after: pc=%h flags=%b flush=%b want %h/000/0",
               pc, flags, flush, p0 + 16'd2);
    end
    flags_we = 3'b010; flags_in = 3'b111;
    step();
    idle();
    vecs++;
    if (flags !== 3'b010) begin
      errs++;
      $display("FAIL partial_we: flags=%b want 010", flags);
    end
  endtask

  task automatic test_conditions();
    for (int f = 0; f < 8; f++) begin
      idle();
      flags_we = 3'b111; flags_in = 3'(f);
      step();
      idle();
      opcode = B; imm = 9'h000;
      for (int c = 0; c < 8; c++) begin
        cond = 3'(c);
        #1;
        vecs++;
        if (taken !== exp_cond(3'(c), 3'(f))) begin
          errs++;
          $display("FAIL cond f=%b c=%b: taken=%b want %b",
                   3'(f), 3'(c), taken, exp_cond(3'(c), 3'(f)));
        end
      end
      idle();
    end
    flags_we = 3'b111; flags_in = 3'b000;
    step();
    idle();
  endtask

  task automatic test_wrap();
    jump(16'hFFFE);
    vecs++;
    if (pc !== 16'hFFFE || pc_plus2 !== 16'h0000) begin
      errs++;
      $display("FAIL wrap_pre: pc=%h pc_plus2=%h want fffe/0000",
               pc, pc_plus2);
    end
    opcode = B; cond = 3'b111; imm = 9'h001;
    step();
    idle();
    vecs++;
    if (pc !== 16'h0002) begin
      errs++;
      $display("FAIL wrap_b: pc=%h want 0002", pc);
    end
    jump(16'hFFFE);
    step();
    vecs++;
    if (pc !== 16'h0000) begin
      errs++;
      $display("FAIL wrap_seq: pc=%h want 0000", pc);
    end
  endtask

  task automatic test_stall();
    logic [15:0] p0, b0, t0;
    p0 = pc; b0 = br_cnt; t0 = tk_cnt;
    opcode = BR; cond = 3'b111; rs_data = 16'h1234; stall = 1;
    flags_we = 3'b111; flags_in = 3'b111;
    for (int i = 0; i < 2; i++) begin
      #1;
      vecs++;
      if (taken !== 1'b0) begin
        errs++;
        $display("FAIL stall_taken %0d: got %b want 0", i, taken);
      end
      step();
      vecs++;
      if (pc !== p0 || flush !== 1'b0 || flags !== 3'b000
          || br_cnt !== b0 || tk_cnt !== t0) begin
        errs++;
        $display("FAIL stall_hold %0d: pc=%h flush=%b flags=%b br=%0d want %h/0/000/%0d",
                 i, pc, flush, flags, br_cnt, p0, b0);
      end
    end
    stall = 0; flags_we = 3'b000;
    #1;
    vecs++;
    if (taken !== 1'b1) begin
      errs++;
      $display("FAIL stall_release_taken: got %b want 1", taken);
    end
    step();
    idle();
    vecs++;
    if (pc !== 16'h1234 || flush !== 1'b1 || br_cnt !== b0 + 16'd1) begin
      errs++;
      $display("FAIL stall_release: pc=%h flush=%b br=%0d want 1234/1/%0d",
               pc, flush, br_cnt, b0 + 16'd1);
    end
    step();
    vecs++;
    if (flush !== 1'b0) begin
      errs++;
      $display("FAIL stall_one_pulse: flush=%b want 0", flush);
    end
  endtask

  task automatic test_halt();
    logic [15:0] b0, t0;
    logic [2:0]  f0;
    jump(16'h0040);
    opcode = HLT;
    step();
    idle();
    b0 = br_cnt; t0 = tk_cnt; f0 = flags;
    vecs++;
    if (halted !== 1'b1 || pc !== 16'h0040) begin
      errs++;
      $display("FAIL halt_enter: halted=%b pc=%h want 1/0040", halted, pc);
    end
    for (int i = 0; i < 10; i++) begin
      stall    = 1'($urandom);
      opcode   = (i % 2 == 0) ? BR : 4'($urandom);
      cond     = 3'b111;
      imm      = 9'($urandom);
      rs_data  = 16'($urandom);
      flags_in = 3'($urandom);
      flags_we = 3'b111;
      #1;
      vecs++;
      if (taken !== 1'b0) begin
        errs++;
        $display("FAIL halt_taken %0d: got %b want 0", i, taken);
      end
      step();
      vecs++;
      if (pc !== 16'h0040 || halted !== 1'b1 || flush !== 1'b0
          || flags !== f0 || br_cnt !== b0 || tk_cnt !== t0) begin
        errs++;
        $display("FAIL halt_frozen %0d: pc=%h halted=%b flush=%b flags=%b",
                 i, pc, halted, flush, flags);
      end
    end
    idle();
    #2;
    rst = 1;
    #1;
    vecs++;
    if (pc !== 16'h0000 || halted !== 1'b0 || br_cnt !== 16'd0) begin
      errs++;
      $display("FAIL halt_async_rst: pc=%h halted=%b br=%0d want 0000/0/0",
               pc, halted, br_cnt);
    end
    step();
    rst = 0;
    step();
    vecs++;
    if (pc !== 16'h0002 || halted !== 1'b0) begin
      errs++;
      $display("FAIL halt_resume: pc=%h halted=%b want 0002/0", pc, halted);
    end
  endtask

  task automatic test_rst_kills_flush();
    idle();
    opcode = B; cond = 3'b111; imm = 9'h020;
    step();
    idle();
    vecs++;
    if (flush !== 1'b1) begin
      errs++;
      $display("FAIL pre_rst_flush: got %b want 1", flush);
    end
    #1;
    rst = 1;
    #1;
    vecs++;
    if (flush !== 1'b0 || pc !== 16'h0000) begin
      errs++;
      $display("FAIL rst_flush: flush=%b pc=%h want 0/0000", flush, pc);
    end
    step();
    rst = 0;
    #2;
  endtask

  task automatic test_saturate();
    do_reset();
    for (int i = 1; i <= 20; i++) begin
      opcode = B; cond = 3'b111; imm = 9'h000;
      step();
      if (i == 14) begin
        vecs++;
        if (br_cnt2 !== 4'd14 || tk_cnt2 !== 4'd14) begin
          errs++;
          $display("FAIL sat_14: br=%0d tk=%0d want 14/14", br_cnt2, tk_cnt2);
        end
      end
      if (i == 15 || i == 20) begin
        vecs++;
        if (br_cnt2 !== 4'd15 || tk_cnt2 !== 4'd15) begin
          errs++;
          $display("FAIL sat_%0d: br=%0d tk=%0d want 15/15",
                   i, br_cnt2, tk_cnt2);
        end
      end
    end
    idle();
    vecs++;
    if (br_cnt !== 16'd20 || tk_cnt !== 16'd20 || pc !== 16'd40) begin
      errs++;
      $display("FAIL wide_cnt: br=%0d tk=%0d pc=%0d want 20/20/40",
               br_cnt, tk_cnt, pc);
    end
  endtask

  initial begin
    rst = 1;
    idle();
    test_reset();
    test_branch_back();
    test_flag_hazard();
    test_conditions();
    test_wrap();
    test_stall();
    test_halt();
    test_rst_kills_flush();
    test_saturate();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 SHALL have parameter WIDTH, default 16, giving the PC, rs_data and target width in bits.
REQ-002 SHALL have parameter IMM_W, default 9, giving the branch immediate width.
REQ-003 SHALL have parameter RESET_PC, default 0, giving the PC value loaded on reset.
REQ-004 SHALL have parameter CNT_W, default 16, giving the statistics counter width.
REQ-005 SHALL use one clock and an asynchronous, active-high reset.
REQ-006 SHALL have port clk, input, 1 bit: rising-edge clock.
REQ-007 SHALL have port rst, input, 1 bit: asynchronous active-high reset.
REQ-008 SHALL have port stall, input, 1 bit: hold all state this cycle.
REQ-009 SHALL have port opcode, input, 4 bits: opcode of the instruction at pc.
REQ-010 SHALL have port cond, input, 3 bits: branch condition code.
REQ-011 SHALL have port imm, input, IMM_W bits: signed halfword branch offset.
REQ-012 SHALL have port rs_data, input, WIDTH bits: register-branch target.
REQ-013 SHALL have port flags_in, input, 3 bits: new flag values {Z,V,N}.
REQ-014 SHALL have port flags_we, input, 3 bits: per-flag write enables {Z,V,N}.
REQ-015 SHALL have port pc, output, WIDTH bits: current fetch address, registered.
REQ-016 SHALL have port pc_plus2, output, WIDTH bits: pc+2, combinational.
REQ-017 SHALL have port taken, output, 1 bit: combinational; the branch at pc is taken this cycle.
REQ-018 SHALL have port flush, output, 1 bit: registered one-cycle redirect pulse.
REQ-019 SHALL have port halted, output, 1 bit: registered; the HALTED state is active.
REQ-020 SHALL have port flags, output, 3 bits: registered {Z,V,N}.
REQ-021 SHALL have port br_cnt, output, CNT_W bits: count of executed branches.
REQ-022 SHALL have port tk_cnt, output, CNT_W bits: count of taken branches.

Function
REQ-023 SHALL implement two states: RUN and HALTED.
REQ-024 SHALL recognise opcodes B=4'b1100, BR=4'b1101 and HLT=4'b1111; all other opcodes are sequential.
REQ-025 SHALL evaluate cond against the registered flags: 000 Z=0; 001 Z=1; 010 Z=0 and N=0; 011 N=1; 100 Z=1 or (Z=0 and N=0); 101 Z=1 or N=1; 110 V=1; 111 always.
REQ-026 SHALL drive taken = (RUN & !stall & opcode in {B,BR} & condition true).
REQ-027 SHALL compute the B target as pc+2 + (sign-extended imm << 1), and the BR target as rs_data.
REQ-028 SHALL perform all target arithmetic modulo 2^WIDTH, so wrap-around is silent.
REQ-029 SHALL, in RUN with stall=0, load pc with the target when taken=1, otherwise with pc+2.
REQ-030 SHALL, in RUN with stall=0 and opcode=HLT, hold pc at the HLT address and enter HALTED on that edge.
REQ-031 SHALL make HALTED terminal: pc, flags and counters frozen; taken=0; flush=0; all inputs ignored until rst.
REQ-032 SHALL set flush to 1 on the edge following taken=1, and to 0 on every other edge, including edges where stall=1.
REQ-033 SHALL, with stall=1, hold pc, flags, counters and state.
REQ-034 SHALL, with stall=0 in RUN, update each flag bit whose flags_we bit is 1 from flags_in, leaving the others unchanged.
REQ-035 SHALL, when a flag write and a branch occur in the same cycle, evaluate the branch with the pre-write flags.
REQ-036 SHALL increment br_cnt on every non-stalled RUN cycle whose opcode is B or BR, and increment tk_cnt when taken=1.
REQ-037 SHALL saturate both counters at 2^CNT_W-1 rather than wrapping.

Reset
REQ-038 SHALL, while rst=1, asynchronously force pc=RESET_PC, state=RUN, flush=0, halted=0, flags=3'b000, br_cnt=0 and tk_cnt=0.
REQ-039 SHALL, when rst is asserted mid-operation, take effect immediately and discard any pending redirect or flush.
REQ-040 SHALL resume execution from RESET_PC on the first rising edge after rst deasserts.

Verification
REQ-041 SHALL cover: pc=0x0010, opcode=B, cond=111, imm=9'h1FE -> taken=1; next pc=0x000E; flush=1 for exactly one cycle; br_cnt=1, tk_cnt=1.
REQ-042 SHALL cover: flags Z=1, opcode=B, cond=000 with flags_we=3'b100 and flags_in Z=0 in the same cycle -> not taken; pc advances by 2; next flags Z=0.
REQ-043 SHALL cover: pc=0xFFFE, opcode=B, cond=111, imm=9'h001 -> pc wraps to 0x0002; all sequential steps from 0xFFFE wrap to 0x0000.
REQ-044 SHALL cover: opcode=BR, cond=111, rs_data=0x1234 with stall=1 for 2 cycles then released -> pc held and taken=0 while stalled; pc=0x1234 after release; one flush pulse.
REQ-045 SHALL cover: opcode=HLT at pc=0x0040 -> halted=1 and pc=0x0040 frozen for 10 cycles regardless of inputs; rst pulse -> pc=RESET_PC, halted=0.
REQ-046 SHALL cover: with CNT_W=4, 20 taken branches -> br_cnt and tk_cnt saturate at 15.
